// File: rtl/appleii_video_decoder.sv
// Apple ][ video decoder: serial video bit to RGB with NTSC-artifact colour,
// monochrome tints, odd-line dimming, and HS/VS/blanking regenerated from HBL/VBL.
`timescale 1ns/1ps
module appleii_video_decoder #(
    parameter int unsigned OUT_W        = 8,
    parameter int unsigned ACTIVE_LEN   = 564,
    parameter int unsigned FRONT_PORCH  = 130,
    parameter int unsigned HSYNC_LEN    = 68,
    parameter int unsigned VBL_TO_VSYNC = 33,
    parameter int unsigned VSYNC_LINES  = 3,
    parameter int unsigned DE_TAP_A     = 9,
    parameter int unsigned DE_TAP_B     = 17
) (
    input  logic             CLK_14M,
    input  logic             RESET_N,
    input  logic             VIDEO,
    input  logic             COLOR_LINE,
    input  logic             MONO_FORCE,
    input  logic [1:0]       SCREEN_MODE,
    input  logic [1:0]       SCANLINES,
    input  logic             HBL,
    input  logic             VBL,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_HBL,
    output logic             VGA_VBL,
    output logic [OUT_W-1:0] VGA_R,
    output logic [OUT_W-1:0] VGA_G,
    output logic [OUT_W-1:0] VGA_B
);

    localparam logic [10:0] HS_START = 11'(ACTIVE_LEN + FRONT_PORCH);
    localparam logic [10:0] HS_END   = 11'(ACTIVE_LEN + FRONT_PORCH + HSYNC_LEN);
    localparam logic [5:0]  VS_ON    = 6'(VBL_TO_VSYNC);
    localparam logic [5:0]  VS_OFF   = 6'(VBL_TO_VSYNC + VSYNC_LINES);

    logic              last_hbl;
    logic              line_seen;   // set by the first HBL fall after reset
    logic              vbl_d;
    logic              parity;
    logic [10:0]       hcount;
    logic [5:0]        vcount;
    logic [5:0]        sw;
    // Only taps up to DE_TAP_B are ever observed, so the pipe stops there.
    logic [DE_TAP_B:0] hbl_pipe;

    logic        line_start;
    logic        hs_rise;
    logic        hs_fall;
    logic [23:0] bg;
    logic [23:0] fg;
    logic [23:0] b_k;
    logic [3:0]  tint_bits;
    logic [9:0]  sum_r;
    logic [9:0]  sum_g;
    logic [9:0]  sum_b;
    logic [23:0] col;
    logic [23:0] col_out;

    // Artifact-colour basis, packed as {R, G, B}.
    function automatic logic [23:0] basis(input logic [1:0] idx);
        logic [23:0] v;
        case (idx)
            2'd0:    v = 24'h503838;
            2'd1:    v = 24'h379410;
            2'd2:    v = 24'h082CB0;
            default: v = 24'h700707;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] sat8(input logic [9:0] s);
        return (s[9:8] != 2'b00) ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] dim(input logic [7:0] c, input logic [1:0] lvl);
        logic [7:0] v;
        case (lvl)
            2'b01:   v = c - (c >> 2);
            2'b10:   v = c >> 1;
            2'b11:   v = c >> 2;
            default: v = c;
        endcase
        return v;
    endfunction

    // {c, c} top-sliced gives truncation below 8 bits and MSB replication above.
    function automatic logic [OUT_W-1:0] widen(input logic [7:0] c);
        logic [15:0] rep;
        rep = {c, c};
        return rep[15 -: OUT_W];
    endfunction

    assign line_start = last_hbl & ~HBL;
    // Line start wins over a coincident HS point.
    assign hs_rise    = line_seen & ~line_start & (hcount == HS_START);
    assign hs_fall    = (hcount == HS_END);
    assign VGA_HBL    = hbl_pipe[DE_TAP_A] & hbl_pipe[DE_TAP_B];
    assign VGA_VBL    = vbl_d;

    // Line timing: HBL edge detect, counters, line parity and blank pipe.
    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            last_hbl  <= 1'b0;
            line_seen <= 1'b0;
            vbl_d     <= 1'b0;
            parity    <= 1'b0;
            hcount    <= '0;
            vcount    <= '0;
            hbl_pipe  <= '0;
        end else begin
            last_hbl <= HBL;
            hbl_pipe <= {hbl_pipe[DE_TAP_B-1:0], last_hbl};
            if (line_start) begin
                hcount    <= '0;
                vbl_d     <= VBL;
                line_seen <= 1'b1;
                if (VBL) begin
                    vcount <= (vcount == 6'd63) ? vcount : vcount + 6'd1;
                    parity <= 1'b0;
                end else begin
                    vcount <= '0;
                    parity <= ~parity;
                end
            end else if (hcount != 11'h7FF) begin
                hcount <= hcount + 11'd1;
            end
        end
    end

    // Sync generation: VS only moves on an HS rising edge.
    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            VGA_HS <= 1'b0;
            VGA_VS <= 1'b0;
        end else if (hs_rise) begin
            VGA_HS <= 1'b1;
            if (vcount == VS_ON) begin
                VGA_VS <= 1'b1;
            end else if (vcount == VS_OFF) begin
                VGA_VS <= 1'b0;
            end
        end else if (hs_fall) begin
            VGA_HS <= 1'b0;
        end
    end

    // Video shift window, newest bit enters at the top.
    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            sw <= '0;
        end else begin
            sw <= {VIDEO, sw[5:1]};
        end
    end

    // Pixel decode from the pre-update window: mono, stable tint or tint transition.
    always_comb begin
        bg      = 24'h000000;
        fg      = 24'hFFFFFF;
        b_k     = 24'h000000;
        col     = 24'h000000;
        col_out = 24'h000000;
        case (SCREEN_MODE)
            2'b10: begin
                bg = 24'h000F01;
                fg = 24'h00C001;
            end
            2'b11: begin
                bg = 24'h200801;
                fg = 24'hFF8001;
            end
            default: ;
        endcase

        // Bit k selects basis[(hcount + k) mod 4]; sw[4] stands in for k = 0.
        tint_bits = {sw[3], sw[2], sw[1], sw[4]};
        sum_r     = {2'b00, bg[23:16]};
        sum_g     = {2'b00, bg[15:8]};
        sum_b     = {2'b00, bg[7:0]};
        for (int k = 0; k < 4; k++) begin
            b_k = basis(hcount[1:0] + 2'(k));
            if (tint_bits[k]) begin
                sum_r = sum_r + {2'b00, b_k[23:16]};
                sum_g = sum_g + {2'b00, b_k[15:8]};
                sum_b = sum_b + {2'b00, b_k[7:0]};
            end
        end

        if (COLOR_LINE | MONO_FORCE) begin
            col = sw[2] ? fg : bg;
        end else if ((sw[0] == sw[4]) && (sw[1] == sw[5])) begin
            col = {sat8(sum_r), sat8(sum_g), sat8(sum_b)};
        end else begin
            case (sw[3:2])
                2'b11:   col = 24'hFFFFFF;
                2'b00:   col = 24'h000000;
                default: col = 24'h808080;
            endcase
        end

        if (parity) begin
            col_out = {dim(col[23:16], SCANLINES), dim(col[15:8], SCANLINES),
                       dim(col[7:0], SCANLINES)};
        end else begin
            col_out = col;
        end
    end

    // Colour output register; held at zero until the first line after reset.
    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else if (line_seen) begin
            VGA_R <= widen(col_out[23:16]);
            VGA_G <= widen(col_out[15:8]);
            VGA_B <= widen(col_out[7:0]);
        end
    end

endmodule

// File: tb/tb_appleii_video_decoder.sv
// Directed bench for appleii_video_decoder: 8-bit, 4-bit and 10-bit instances
// share one stimulus stream.
`timescale 1ns/1ps
module tb_appleii_video_decoder;

    logic clk = 1'b0;
    logic rst_n, video, color_line, mono_force, hbl, vbl;
    logic [1:0] screen_mode, scanlines;

    logic hs, vs, vhbl, vvbl;
    logic [7:0] r8, g8, b8;
    logic hs4, vs4, vhbl4, vvbl4;
    logic [3:0] r4, g4, b4;
    logic hs10, vs10, vhbl10, vvbl10;
    logic [9:0] r10, g10, b10;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int exp_par = 0;
    int rises, rise_m, width, vbl_rises;
    logic hs0, vs_end;
    logic [63:0] vs_mask;

    appleii_video_decoder #(.OUT_W(8)) dut8 (
        .CLK_14M(clk), .RESET_N(rst_n), .VIDEO(video), .COLOR_LINE(color_line),
        .MONO_FORCE(mono_force), .SCREEN_MODE(screen_mode), .SCANLINES(scanlines),
        .HBL(hbl), .VBL(vbl), .VGA_HS(hs), .VGA_VS(vs), .VGA_HBL(vhbl), .VGA_VBL(vvbl),
        .VGA_R(r8), .VGA_G(g8), .VGA_B(b8)
    );

    appleii_video_decoder #(.OUT_W(4)) dut4 (
        .CLK_14M(clk), .RESET_N(rst_n), .VIDEO(video), .COLOR_LINE(color_line),
        .MONO_FORCE(mono_force), .SCREEN_MODE(screen_mode), .SCANLINES(scanlines),
        .HBL(hbl), .VBL(vbl), .VGA_HS(hs4), .VGA_VS(vs4), .VGA_HBL(vhbl4), .VGA_VBL(vvbl4),
        .VGA_R(r4), .VGA_G(g4), .VGA_B(b4)
    );

    appleii_video_decoder #(.OUT_W(10)) dut10 (
        .CLK_14M(clk), .RESET_N(rst_n), .VIDEO(video), .COLOR_LINE(color_line),
        .MONO_FORCE(mono_force), .SCREEN_MODE(screen_mode), .SCANLINES(scanlines),
        .HBL(hbl), .VBL(vbl), .VGA_HS(hs10), .VGA_VS(vs10), .VGA_HBL(vhbl10),
        .VGA_VBL(vvbl10), .VGA_R(r10), .VGA_G(g10), .VGA_B(b10)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line of len edges starting with the HBL fall; HBL rises at edge low_len.
    task automatic run_line(input logic v, input int len, input int low_len,
                            input bit chk_blank);
        logic prev;
        prev = hs;
        hbl  = 1'b0;
        vbl  = v;
        step();
        exp_par = v ? 0 : 1 - exp_par;
        hs0    = hs;
        rises  = 0;
        rise_m = -1;
        width  = 0;
        if (hs && !prev) begin rises++; rise_m = 0; end
        if (hs) width++;
        prev = hs;
        for (int m = 1; m < len; m++) begin
            hbl = (m >= low_len);
            step();
            if (hs && !prev) begin rises++; rise_m = m; end
            if (hs) width++;
            prev = hs;
            if (chk_blank && m == 9)   chk("hbl tap9 still high", 64'(vhbl), 64'd1);
            if (chk_blank && m == 10)  chk("hbl tap9 fall", 64'(vhbl), 64'd0);
            if (chk_blank && m == 757) chk("hbl tap17 still low", 64'(vhbl), 64'd0);
            if (chk_blank && m == 758) chk("hbl tap17 rise", 64'(vhbl), 64'd1);
        end
        vs_end = vs;
    endtask

    initial begin
        logic [23:0] basis_tbl [4];
        int cnt;
        basis_tbl[0] = 24'h503838;
        basis_tbl[1] = 24'h379410;
        basis_tbl[2] = 24'h082CB0;
        basis_tbl[3] = 24'h700707;

        rst_n = 1'b0; video = 1'b0; color_line = 1'b1; mono_force = 1'b0;
        hbl = 1'b0; vbl = 1'b0; screen_mode = 2'b00; scanlines = 2'b00;
        repeat (3) step();
        chk("reset dut8", 64'({hs, vs, vhbl, vvbl, r8, g8, b8}), 64'd0);
        chk("reset dut4", 64'({hs4, vs4, vhbl4, vvbl4, r4, g4, b4}), 64'd0);
        chk("reset dut10", 64'({hs10, vs10, vhbl10, vvbl10, r10, g10, b10}), 64'd0);
        rst_n = 1'b1;
        hbl = 1'b1;
        repeat (30) step();

        // Sync geometry and blanking taps.
        run_line(1'b0, 912, 740, 1'b0);
        run_line(1'b0, 912, 740, 1'b1);
        chk("hs rise position", 64'(rise_m), 64'd695);
        chk("hs width", 64'(width), 64'd68);
        chk("hs pulses per line", 64'(rises), 64'd1);
        vbl_rises = 0;
        vs_mask = '0;
        for (int n = 1; n <= 40; n++) begin
            run_line(1'b1, 912, 740, 1'b0);
            vbl_rises += rises;
            vs_mask[n] = vs_end;
        end
        chk("vga_vbl in vbl", 64'(vvbl), 64'd1);
        chk("hs pulses in vbl", 64'(vbl_rises), 64'd40);
        chk("vs lines high", vs_mask, 64'h0000_000E_0000_0000);
        run_line(1'b0, 912, 740, 1'b0);
        chk("vga_vbl after vbl", 64'(vvbl), 64'd0);
        chk("vs after vbl", 64'(vs), 64'd0);

        // Short line; next line start lands exactly on the HS point.
        run_line(1'b0, 695, 600, 1'b0);
        chk("short line hs pulses", 64'(rises), 64'd0);
        run_line(1'b0, 912, 740, 1'b0);
        chk("hs at coincident line start", 64'(hs0), 64'd0);
        chk("hs rise after short line", 64'(rise_m), 64'd695);

        // Scanline dimming on white mono.
        video = 1'b1; color_line = 1'b1; scanlines = 2'b10;
        for (int l = 0; l < 2; l++) begin
            run_line(1'b0, 60, 50, 1'b0);
            chk("dim50 dut8", 64'({r8, g8, b8}),
                64'(exp_par ? 24'h7F7F7F : 24'hFFFFFF));
            chk("dim50 dut4", 64'({r4, g4, b4}), 64'(exp_par ? 12'h777 : 12'hFFF));
            chk("dim50 dut10", 64'({r10, g10, b10}),
                exp_par ? 64'({10'h1FD, 10'h1FD, 10'h1FD}) : 64'({10'h3FF, 10'h3FF, 10'h3FF}));
        end
        scanlines = 2'b01;
        for (int l = 0; l < 2; l++) begin
            run_line(1'b0, 60, 50, 1'b0);
            chk("dim25", 64'({r8, g8, b8}), 64'(exp_par ? 24'hC0C0C0 : 24'hFFFFFF));
        end
        scanlines = 2'b11;
        for (int l = 0; l < 2; l++) begin
            run_line(1'b0, 60, 50, 1'b0);
            chk("dim75", 64'({r8, g8, b8}), 64'(exp_par ? 24'h3F3F3F : 24'hFFFFFF));
        end
        scanlines = 2'b00;

        // Mono latency: single pulse sampled at edge N appears after edge N+4.
        screen_mode = 2'b10; video = 1'b0;
        repeat (10) step();
        video = 1'b1;
        step();
        video = 1'b0;
        chk("mono lat N", 64'({r8, g8, b8}), 64'h000F01);
        step(); chk("mono lat N+1", 64'({r8, g8, b8}), 64'h000F01);
        step(); chk("mono lat N+2", 64'({r8, g8, b8}), 64'h000F01);
        step(); chk("mono lat N+3", 64'({r8, g8, b8}), 64'h000F01);
        step(); chk("mono lat N+4", 64'({r8, g8, b8}), 64'h00C001);
        step(); chk("mono lat N+5", 64'({r8, g8, b8}), 64'h000F01);

        // Forced monochrome overrides a colour line.
        color_line = 1'b0; mono_force = 1'b1; screen_mode = 2'b11; video = 1'b1;
        repeat (6) step();
        chk("mono force fg amber", 64'({r8, g8, b8}), 64'hFF8001);
        video = 1'b0;
        repeat (6) step();
        chk("mono force bg amber", 64'({r8, g8, b8}), 64'h200801);
        mono_force = 1'b0;

        // Tint transitions: three ones, then zeros.
        screen_mode = 2'b00; video = 1'b0;
        repeat (8) step();
        video = 1'b1;
        repeat (3) step();
        video = 1'b0;
        step();
        step(); chk("tint change 11 a", 64'({r8, g8, b8}), 64'hFFFFFF);
        step(); chk("tint change 11 b", 64'({r8, g8, b8}), 64'hFFFFFF);
        step(); chk("tint change 10", 64'({r8, g8, b8}), 64'h808080);
        step(); chk("tint change 00", 64'({r8, g8, b8}), 64'h000000);

        // All-ones stable tint, plain and with saturation against green background.
        video = 1'b1;
        repeat (10) step();
        chk("colour all ones", 64'({r8, g8, b8}), 64'hFFFFFF);
        screen_mode = 2'b10;
        step();
        chk("colour clamp green", 64'({r8, g8, b8}), 64'hFFFFFF);
        screen_mode = 2'b00;

        // 1000 pattern at phase p relative to line start selects basis[(p+1) mod 4].
        for (int p = 0; p < 4; p++) begin
            hbl = 1'b1; video = 1'b0;
            repeat (20) step();
            hbl = 1'b0;
            step();
            exp_par = 1 - exp_par;
            for (int m = 1; m <= 24; m++) begin
                video = ((m % 4) == p);
                step();
                if (m == 20 || m == 21)
                    chk("colour basis phase", 64'({r8, g8, b8}), 64'(basis_tbl[(p + 1) % 4]));
            end
        end

        // Saturated hcount: one HS with HBL held low, none with HBL held high.
        hbl = 1'b1;
        repeat (20) step();
        run_line(1'b0, 3000, 3000, 1'b0);
        chk("hs pulses hbl held low", 64'(rises), 64'd1);
        hbl = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            logic p0;
            p0 = hs;
            step();
            if (hs && !p0) cnt++;
        end
        chk("hs pulses hbl held high", 64'(cnt), 64'd0);
        chk("hs low at end of saturation", 64'(hs), 64'd0);

        // Mid-line asynchronous reset while HS is high.
        color_line = 1'b1; video = 1'b1;
        run_line(1'b0, 701, 701, 1'b0);
        chk("hs high before reset", 64'(hs), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset dut8", 64'({hs, vs, vhbl, vvbl, r8, g8, b8}), 64'd0);
        chk("async reset dut4", 64'({hs4, vs4, vhbl4, vvbl4, r4, g4, b4}), 64'd0);
        chk("async reset dut10", 64'({hs10, vs10, vhbl10, vvbl10, r10, g10, b10}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            video = ~video;
            step();
            chk("held reset dut8", 64'({hs, vs, vhbl, vvbl, r8, g8, b8}), 64'd0);
        end
        rst_n = 1'b1;
        exp_par = 0;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            video = ~video;
            step();
            if (hs) cnt++;
        end
        chk("no hs before first line", 64'(cnt), 64'd0);
        hbl = 1'b1;
        repeat (20) step();
        run_line(1'b0, 912, 740, 1'b0);
        chk("hs rise after reset", 64'(rise_m), 64'd695);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
